udma_l2_wr_arbiter: RTL and testbench
=====================================

# udma_l2_wr_arbiter

Shares the single uDMA L2 write port between `N_CH` RX stream sources, such as linear RX channels and stream producers. Each source presents a `udma_stream_req_t` and receives a `udma_stream_rsp_t`. Sources are granted round-robin. The winning beat is registered in a one-entry output stage and converted into a word-addressed, byte-enabled L2 write. That write is held on a req/gnt handshake until the L2 interconnect accepts it.

## Interface
Parameters:
- `N_CH`, 4, number of requesting stream sources (2..16)
- `CH_ID_W`, `$clog2(N_CH)`, width of the winner-index output

Ports:
- `clk_i`  in  1  system clock
- `rstn_i`  in  1  reset; one clock, reset is synchronous and active-low
- `ch_req_i`  in  `N_CH` x `udma_stream_req_t`  per-source addr (`L2_AWIDTH_NOAL` byte address), datasize, data, valid
- `ch_rsp_o`  out  `N_CH` x `udma_stream_rsp_t`  per-source ready
- `l2_req_o`  out  1  write request to L2
- `l2_gnt_i`  in  1  L2 grant; a transfer completes when `l2_req_o & l2_gnt_i`
- `l2_addr_o`  out  `L2_ADDR_WIDTH`  word address, equal to byte addr[20:2]
- `l2_we_o`  out  1  constant 1 while `l2_req_o`
- `l2_be_o`  out  4  byte enables
- `l2_wdata_o`  out  32  lane-replicated write data
- `l2_ch_o`  out  `CH_ID_W`  index of the source owning the current request
- `busy_o`  out  1  output stage full

## Operation
- Output stage is a two-state FSM:
  - EMPTY -> FULL when any source is valid.
  - FULL -> EMPTY on gnt with no valid source.
  - FULL stays FULL on gnt with a valid source (back-to-back reload).
  - FULL stays FULL on no gnt (hold).
- `load = valid_any & (state==EMPTY | l2_gnt_i)`.
- `ch_rsp_o[i].ready = load & grant[i]`. It is combinational, one-hot, and asserted only on the cycle the beat is captured.
- Round-robin arbitration:
  - Priority search starts at pointer `ptr`.
  - On `load`, `ptr <= winner+1` (mod `N_CH`).
  - `ptr` is unchanged otherwise.
  - Reset value of `ptr` is 0.
- Datasize encoding (`udma_pkg`): 00 byte, 01 half, 10 word, 11 reserved and treated as word.
- Byte enables and data:
  - byte: be = `4'b0001 << addr[1:0]`; wdata = data[7:0] replicated x4.
  - half: be = addr[1] ? 1100 : 0011; wdata = data[15:0] replicated x2; addr[0] ignored.
  - word: be = 1111; wdata = data; addr[1:0] ignored.
- A valid source that is not granted keeps its request; sources must hold their fields stable until ready.
- Reset values: `state`=EMPTY; `l2_req_o`=0; `l2_addr_o`, `l2_be_o`, `l2_wdata_o`, `l2_ch_o` = 0; `busy_o`=0; all ready=0.

## Timing
- Latency: a beat accepted in cycle t (valid & ready) drives `l2_req_o`=1 from cycle t+1.
- Throughput: 1 beat/cycle while `l2_gnt_i` is held high.
- While `l2_req_o & !l2_gnt_i`, addr/be/wdata/ch are stable and no source gets ready.
- A gnt in the same cycle as a new valid reloads the stage with no bubble.
- Deasserting `rstn_i` mid-request drops the held beat. There is no completion and no ready next cycle; `l2_req_o`=0 one cycle after the reset edge.
- `l2_gnt_i` while `l2_req_o`=0 is ignored.

## Structure
- `udma_pkg` gains:
  - `l2_be_t` (`logic [3:0]`)
  - localparams `UDMA_DSIZE_BYTE`=2'b00, `UDMA_DSIZE_HALF`=2'b01, `UDMA_DSIZE_WORD`=2'b10
- Sub-module `udma_rr_arb` (params `N_CH`): request vector in; one-hot grant plus index out; internal `ptr` advanced by an `update_i` strobe (driven by `load`).
- Lane/be formatting stays in the top level as combinational logic ahead of the output register.

## Test plan
- Single source 0, byte at addr 0x00103, data 0xAB, gnt tied 1:
  - ready in cycle t; `l2_req_o` in t+1 with addr 0x00040, be 1000, wdata 0xABABABAB, ch 0.
- Half at addr 0x00006, data 0x1234:
  - be 1100, wdata 0x12341234.
- Word at addr 0x00011 (misaligned), data 0xDEADBEEF:
  - addr 0x00004, be 1111, wdata 0xDEADBEEF.
- All 4 sources continuously valid, gnt=1:
  - ch sequence 0,1,2,3,0,1…; each ready once per 4 cycles; no two readies in the same cycle.
- Source 2 valid, gnt held 0 for 5 cycles, then 1:
  - outputs stable for 5 cycles; no ready during the stall; the next beat is loaded in the gnt cycle with no bubble.
- Request pending, `rstn_i`=0 for 1 cycle:
  - `l2_req_o`=0 and `busy_o`=0 after the edge; `ptr` reset, so the next grant goes to the lowest valid index.

Source files
------------

// File: rtl/udma_pkg.sv
// Shared uDMA types: stream source request/response, L2 byte enables and
// the datasize encoding used by the RX stream sources.
package udma_pkg;

  localparam int L2_AWIDTH_NOAL = 21;
  localparam int L2_ADDR_WIDTH  = 19;
  localparam int UDMA_DATA_W    = 32;

  localparam logic [1:0] UDMA_DSIZE_BYTE = 2'b00;
  localparam logic [1:0] UDMA_DSIZE_HALF = 2'b01;
  localparam logic [1:0] UDMA_DSIZE_WORD = 2'b10;

  typedef logic [3:0] l2_be_t;

  typedef struct packed {
    logic [L2_AWIDTH_NOAL-1:0] addr;
    logic [1:0]                datasize;
    logic [UDMA_DATA_W-1:0]    data;
    logic                      valid;
  } udma_stream_req_t;

  typedef struct packed {
    logic ready;
  } udma_stream_rsp_t;

  typedef enum logic {
    OSTG_EMPTY = 1'b0,
    OSTG_FULL  = 1'b1
  } ostg_state_e;

endpackage

// File: rtl/udma_rr_arb.sv
// Round-robin arbiter: the search starts at r_ptr; r_ptr moves to one past
// the winner only when the caller strobes update_i.
module udma_rr_arb #(
  parameter int N_CH    = 4,
  parameter int CH_ID_W = $clog2(N_CH)
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic [N_CH-1:0]    req_i,
  input  logic               update_i,
  output logic [N_CH-1:0]    gnt_o,
  output logic [CH_ID_W-1:0] idx_o,
  output logic               valid_o
);

  logic [CH_ID_W-1:0] r_ptr;

  always_comb begin
    int c;
    c       = 0;
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      c = int'(r_ptr) + k;
      if (c >= N_CH) c = c - N_CH;
      if (!valid_o && req_i[c]) begin
        valid_o  = 1'b1;
        gnt_o[c] = 1'b1;
        idx_o    = CH_ID_W'(c);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_ptr <= '0;
    end else if (update_i) begin
      r_ptr <= (idx_o == CH_ID_W'(N_CH - 1)) ? '0 : idx_o + CH_ID_W'(1);
    end
  end

endmodule

// File: rtl/udma_l2_wr_arbiter.sv
// Shares the L2 write port between N_CH RX stream sources: round-robin pick,
// lane/byte-enable formatting, then a one-entry stage held on req/gnt.
//   state | meaning
//   EMPTY | no beat held, l2_req_o low
//   FULL  | beat held, l2_req_o high until granted
module udma_l2_wr_arbiter
  import udma_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int CH_ID_W = $clog2(N_CH)
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  udma_stream_req_t         ch_req_i [N_CH],
  output udma_stream_rsp_t         ch_rsp_o [N_CH],
  output logic                     l2_req_o,
  input  logic                     l2_gnt_i,
  output logic [L2_ADDR_WIDTH-1:0] l2_addr_o,
  output logic                     l2_we_o,
  output l2_be_t                   l2_be_o,
  output logic [UDMA_DATA_W-1:0]   l2_wdata_o,
  output logic [CH_ID_W-1:0]       l2_ch_o,
  output logic                     busy_o
);

  ostg_state_e r_state;
  ostg_state_e w_state_nxt;

  logic [N_CH-1:0]          w_valid;
  logic [N_CH-1:0]          w_gnt;
  logic [CH_ID_W-1:0]       w_idx;
  logic                     w_any;
  logic                     w_load;

  logic [L2_AWIDTH_NOAL-1:0] w_baddr;
  logic [1:0]                w_dsize;
  logic [UDMA_DATA_W-1:0]    w_data;
  l2_be_t                    w_be;
  logic [UDMA_DATA_W-1:0]    w_wdata;

  logic [L2_ADDR_WIDTH-1:0]  r_addr;
  l2_be_t                    r_be;
  logic [UDMA_DATA_W-1:0]    r_wdata;
  logic [CH_ID_W-1:0]        r_ch;

  always_comb begin
    w_valid = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_valid[i] = ch_req_i[i].valid;
    end
  end

  udma_rr_arb #(
    .N_CH    (N_CH),
    .CH_ID_W (CH_ID_W)
  ) i_rr_arb (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .req_i    (w_valid),
    .update_i (w_load),
    .gnt_o    (w_gnt),
    .idx_o    (w_idx),
    .valid_o  (w_any)
  );

  // Gated by rstn_i so no source sees ready while reset is asserted.
  assign w_load = rstn_i & w_any & ((r_state == OSTG_EMPTY) | l2_gnt_i);

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      ch_rsp_o[i]       = '0;
      ch_rsp_o[i].ready = w_load & w_gnt[i];
    end
  end

  assign w_baddr = ch_req_i[w_idx].addr;
  assign w_dsize = ch_req_i[w_idx].datasize;
  assign w_data  = ch_req_i[w_idx].data;

  // Reserved datasize 2'b11 falls through to the word case.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = w_data;
    case (w_dsize)
      UDMA_DSIZE_BYTE: begin
        w_be    = 4'b0001 << w_baddr[1:0];
        w_wdata = {4{w_data[7:0]}};
      end
      UDMA_DSIZE_HALF: begin
        w_be    = w_baddr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{w_data[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = w_data;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_state <= OSTG_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      OSTG_EMPTY: if (w_load) w_state_nxt = OSTG_FULL;
      OSTG_FULL:  if (l2_gnt_i && !w_any) w_state_nxt = OSTG_EMPTY;
      default:    w_state_nxt = OSTG_EMPTY;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_addr  <= '0;
      r_be    <= '0;
      r_wdata <= '0;
      r_ch    <= '0;
    end else if (w_load) begin
      r_addr  <= w_baddr[L2_AWIDTH_NOAL-1:2];
      r_be    <= w_be;
      r_wdata <= w_wdata;
      r_ch    <= w_idx;
    end
  end

  assign l2_req_o   = (r_state == OSTG_FULL);
  assign l2_we_o    = l2_req_o;
  assign busy_o     = l2_req_o;
  assign l2_addr_o  = r_addr;
  assign l2_be_o    = r_be;
  assign l2_wdata_o = r_wdata;
  assign l2_ch_o    = r_ch;

endmodule

// File: tb/tb_udma_l2_wr_arbiter.sv
// Bench for udma_l2_wr_arbiter: directed steps then random traffic, checked
// against a cycle-level reference model of the arbitration/formatting rules.
module tb_udma_l2_wr_arbiter;
  import udma_pkg::*;

  localparam int N = 4;
  localparam int W = 2;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic gnt = 1'b0;
  udma_stream_req_t req [N];
  udma_stream_rsp_t rsp [N];
  logic             l2_req, l2_we, busy;
  logic [18:0]      l2_addr;
  logic [3:0]       l2_be;
  logic [31:0]      l2_wdata;
  logic [W-1:0]     l2_ch;

  int total = 0;
  int bad   = 0;

  // reference model state
  bit          m_full = 0;
  bit          m_zero = 1;
  int          m_ptr  = 0;
  logic [18:0] m_addr = '0;
  logic [3:0]  m_be   = '0;
  logic [31:0] m_wdata = '0;
  int          m_ch   = 0;
  bit          refill = 0;

  udma_l2_wr_arbiter #(.N_CH(N)) dut (
    .clk_i      (clk),
    .rstn_i     (rstn),
    .ch_req_i   (req),
    .ch_rsp_o   (rsp),
    .l2_req_o   (l2_req),
    .l2_gnt_i   (gnt),
    .l2_addr_o  (l2_addr),
    .l2_we_o    (l2_we),
    .l2_be_o    (l2_be),
    .l2_wdata_o (l2_wdata),
    .l2_ch_o    (l2_ch),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic udma_stream_req_t mk(input logic [20:0] a, input logic [1:0] ds, input logic [31:0] d);
    udma_stream_req_t r;
    r.addr = a; r.datasize = ds; r.data = d; r.valid = 1'b1;
    return r;
  endfunction

  function automatic udma_stream_req_t rand_beat();
    return mk(21'($urandom), 2'($urandom), $urandom);
  endfunction

  // Expected lanes from plain arithmetic on the byte address and data.
  task automatic ref_fmt(input udma_stream_req_t r, output logic [3:0] be, output logic [31:0] wd);
    int a;
    a = int'(r.addr % 4);
    if (r.datasize == 2'd0) begin
      be = 4'(1 << a);
      wd = (r.data % 256) * 32'h01010101;
    end else if (r.datasize == 2'd1) begin
      be = (a >= 2) ? 4'd12 : 4'd3;
      wd = (r.data % 65536) * 32'h00010001;
    end else begin
      be = 4'd15;
      wd = r.data;
    end
  endtask

  task automatic cycle();
    logic [N-1:0] exp_rdy, obs_rdy;
    bit ld;
    int w, c;
    @(negedge clk); #1;
    w = -1;
    for (int k = 0; k < N; k++) begin
      c = (m_ptr + k) % N;
      if (w < 0 && req[c].valid) w = c;
    end
    ld = rstn && (w >= 0) && (!m_full || gnt);
    exp_rdy = '0;
    if (ld) exp_rdy[w] = 1'b1;
    for (int i = 0; i < N; i++) obs_rdy[i] = rsp[i].ready;
    chk("ready", 64'(obs_rdy), 64'(exp_rdy));
    @(posedge clk); #1;
    if (!rstn) begin
      m_full = 0; m_zero = 1; m_ptr = 0;
      m_addr = '0; m_be = '0; m_wdata = '0; m_ch = 0;
    end else if (ld) begin
      m_full = 1; m_zero = 0;
      m_ptr  = (w + 1) % N;
      m_addr = 19'(req[w].addr / 4);
      ref_fmt(req[w], m_be, m_wdata);
      m_ch = w;
      req[w] = refill ? rand_beat() : '0;
    end else if (m_full && gnt) begin
      m_full = 0;
    end
    chk("l2_req", 64'(l2_req), 64'(m_full));
    chk("busy", 64'(busy), 64'(m_full));
    chk("l2_we", 64'(l2_we), 64'(m_full));
    if (m_full || m_zero) begin
      chk("l2_addr", 64'(l2_addr), 64'(m_addr));
      chk("l2_be", 64'(l2_be), 64'(m_be));
      chk("l2_wdata", 64'(l2_wdata), 64'(m_wdata));
      chk("l2_ch", 64'(l2_ch), 64'(m_ch));
    end
  endtask

  initial begin
    logic [18:0] s_addr;
    logic [31:0] s_wdata;
    for (int i = 0; i < N; i++) req[i] = '0;

    // reset state
    rstn = 1'b0; gnt = 1'b1;
    cycle(); cycle();
    rstn = 1'b1;

    // byte beat: ch0, addr 0x00103, data 0xAB
    req[0] = mk(21'h00103, 2'b00, 32'h000000AB);
    cycle();
    chk("tp_byte_addr", 64'(l2_addr), 64'h40);
    chk("tp_byte_be", 64'(l2_be), 64'b1000);
    chk("tp_byte_wdata", 64'(l2_wdata), 64'hABABABAB);
    chk("tp_byte_ch", 64'(l2_ch), 64'd0);

    // half beat back-to-back
    req[0] = mk(21'h00006, 2'b01, 32'h00001234);
    cycle();
    chk("tp_half_be", 64'(l2_be), 64'b1100);
    chk("tp_half_wdata", 64'(l2_wdata), 64'h12341234);

    // misaligned word beat
    req[0] = mk(21'h00011, 2'b10, 32'hDEADBEEF);
    cycle();
    chk("tp_word_addr", 64'(l2_addr), 64'h4);
    chk("tp_word_be", 64'(l2_be), 64'b1111);
    chk("tp_word_wdata", 64'(l2_wdata), 64'hDEADBEEF);

    // all four continuously valid: pointer sits at 1 after three ch0 wins
    refill = 1;
    for (int i = 0; i < N; i++) req[i] = rand_beat();
    for (int k = 0; k < 8; k++) begin
      cycle();
      chk("rr_seq", 64'(l2_ch), 64'((1 + k) % N));
    end

    // drain, then stall source 2 for 5 cycles
    refill = 0;
    for (int i = 0; i < N; i++) req[i] = '0;
    cycle();
    refill = 1; gnt = 1'b0;
    req[2] = rand_beat();
    cycle();
    s_addr = l2_addr; s_wdata = l2_wdata;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("stall_addr", 64'(l2_addr), 64'(s_addr));
      chk("stall_wdata", 64'(l2_wdata), 64'(s_wdata));
    end
    gnt = 1'b1;
    cycle();
    chk("stall_reload_req", 64'(l2_req), 64'd1);
    chk("stall_reload_ch", 64'(l2_ch), 64'd2);

    // reset with a request pending; pointer was 3, must return to 0
    gnt = 1'b0; rstn = 1'b0;
    cycle();
    chk("rst_req", 64'(l2_req), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rstn = 1'b1; refill = 0;
    req[2] = '0;
    req[1] = rand_beat();
    req[3] = rand_beat();
    cycle();
    chk("post_rst_ch", 64'(l2_ch), 64'd1);

    // random traffic
    refill = 0;
    for (int n = 0; n < 500; n++) begin
      for (int i = 0; i < N; i++)
        if (!req[i].valid && ($urandom % 2 == 0)) req[i] = rand_beat();
      gnt  = ($urandom % 4) != 0;
      rstn = ($urandom % 64) != 0;
      cycle();
    end
    rstn = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
